// File: rtl/circle_tracer.sv
// Sequencer that walks the circle point stepper once around a circle of radius r,
// streaming every point out on a valid/ready port and flagging range, stall and watchdog faults.
module circle_tracer #(
  parameter int unsigned W         = 16,
  parameter int unsigned STEP_LAT  = 1,
  parameter int unsigned MAX_STEPS = 2048
) (
  input  logic         mclock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] radius,
  output logic         busy,
  output logic         done,
  output logic [1:0]   err,
  output logic [W-1:0] st_x,
  output logic [W-1:0] st_y,
  output logic [W-1:0] st_r2,
  input  logic [W-1:0] st_ox,
  input  logic [W-1:0] st_oy,
  output logic [W-1:0] pt_x,
  output logic [W-1:0] pt_y,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic [W-1:0] pt_count
);

  localparam int unsigned W2    = 2 * W;
  localparam int unsigned LAT_W = $clog2(STEP_LAT + 1);

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_STALL = 2'd2;
  localparam logic [1:0] ERR_WDOG  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_STEP,
    S_CHECK,
    S_FIN
  } state_t;

  state_t             r_state, w_state;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic [1:0]         r_err, w_err;
  logic [W-1:0]       r_st_x, w_st_x;
  logic [W-1:0]       r_st_y, w_st_y;
  logic [W-1:0]       r_st_r2, w_st_r2;
  logic [W-1:0]       r_pt_x, w_pt_x;
  logic [W-1:0]       r_pt_y, w_pt_y;
  logic               r_pt_valid, w_pt_valid;
  logic [W-1:0]       r_pt_count, w_pt_count;
  logic [W-1:0]       r_start_y, w_start_y;
  logic [W-1:0]       r_nx, w_nx;
  logic [W-1:0]       r_ny, w_ny;
  logic [LAT_W-1:0]   r_lat, w_lat;

  logic [W2-1:0]      w_r2_full;
  logic               w_r2_big;
  logic [W-1:0]       w_cnt_inc;
  logic               w_xfer;

  // r^2 overflows the signed W-bit stepper port once it reaches 2^(W-1)
  assign w_r2_full = W2'(radius) * W2'(radius);
  assign w_r2_big  = |w_r2_full[W2-1:W-1];
  assign w_cnt_inc = r_pt_count + W'(1);
  assign w_xfer    = r_pt_valid & pt_ready;

  always_ff @(posedge mclock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state;
  end

  always_comb begin
    w_state    = r_state;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_err      = r_err;
    w_st_x     = r_st_x;
    w_st_y     = r_st_y;
    w_st_r2    = r_st_r2;
    w_pt_x     = r_pt_x;
    w_pt_y     = r_pt_y;
    w_pt_valid = r_pt_valid;
    w_pt_count = r_pt_count;
    w_start_y  = r_start_y;
    w_nx       = r_nx;
    w_ny       = r_ny;
    w_lat      = r_lat;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pt_count = '0;
          if (w_r2_big) begin
            w_err   = ERR_RANGE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_state = S_FIN;
          end else begin
            w_err      = ERR_OK;
            w_st_r2    = w_r2_full[W-1:0];
            w_st_x     = '0;
            w_st_y     = radius;
            w_start_y  = radius;
            w_pt_x     = '0;
            w_pt_y     = radius;
            w_pt_valid = 1'b1;
            w_busy     = 1'b1;
            w_state    = S_EMIT;
          end
        end
      end

      S_EMIT: begin
        if (w_xfer) begin
          w_pt_count = w_cnt_inc;
          w_pt_valid = 1'b0;
          if (r_start_y == '0) begin
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_state = S_FIN;
          end else if (w_cnt_inc == W'(MAX_STEPS)) begin
            w_err   = ERR_WDOG;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_state = S_FIN;
          end else begin
            w_lat   = '0;
            w_state = S_STEP;
          end
        end
      end

      // Stepper inputs have been stable since EMIT; wait out its latency, then sample
      S_STEP: begin
        if (r_lat == LAT_W'(STEP_LAT)) begin
          w_nx    = st_ox;
          w_ny    = st_oy;
          w_state = S_CHECK;
        end else begin
          w_lat = r_lat + LAT_W'(1);
        end
      end

      S_CHECK: begin
        if (r_nx == r_st_x && r_ny == r_st_y) begin
          w_err   = ERR_STALL;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_FIN;
        end else if (r_nx == '0 && r_ny == r_start_y) begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_FIN;
        end else begin
          w_st_x     = r_nx;
          w_st_y     = r_ny;
          w_pt_x     = r_nx;
          w_pt_y     = r_ny;
          w_pt_valid = 1'b1;
          w_state    = S_EMIT;
        end
      end

      S_FIN: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge mclock or posedge reset) begin
    if (reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= ERR_OK;
      r_st_x     <= '0;
      r_st_y     <= '0;
      r_st_r2    <= '0;
      r_pt_x     <= '0;
      r_pt_y     <= '0;
      r_pt_valid <= 1'b0;
      r_pt_count <= '0;
      r_start_y  <= '0;
      r_nx       <= '0;
      r_ny       <= '0;
      r_lat      <= '0;
    end else begin
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
      r_st_x     <= w_st_x;
      r_st_y     <= w_st_y;
      r_st_r2    <= w_st_r2;
      r_pt_x     <= w_pt_x;
      r_pt_y     <= w_pt_y;
      r_pt_valid <= w_pt_valid;
      r_pt_count <= w_pt_count;
      r_start_y  <= w_start_y;
      r_nx       <= w_nx;
      r_ny       <= w_ny;
      r_lat      <= w_lat;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign st_x     = r_st_x;
  assign st_y     = r_st_y;
  assign st_r2    = r_st_r2;
  assign pt_x     = r_pt_x;
  assign pt_y     = r_pt_y;
  assign pt_valid = r_pt_valid;
  assign pt_count = r_pt_count;

endmodule

// File: tb/tb_circle_tracer.sv
// Bench for circle_tracer: behavioural stepper plus a point-list reference model,
// randomized ready backpressure and radii, fault steppers, reset and busy-start cases.
module tb_circle_tracer;

  localparam int unsigned W         = 16;
  localparam int unsigned STEP_LAT  = 1;
  localparam int unsigned MAX_STEPS = 2048;

  logic         mclock;
  logic         reset;
  logic         start;
  logic [W-1:0] radius;
  logic         busy;
  logic         done;
  logic [1:0]   err;
  logic [W-1:0] st_x, st_y, st_r2;
  logic [W-1:0] st_ox, st_oy;
  logic [W-1:0] pt_x, pt_y;
  logic         pt_valid;
  logic         pt_ready;
  logic [W-1:0] pt_count;

  int errors = 0;
  int checks = 0;
  int mode   = 0;   // 0 circle stepper, 1 returns input, 2 bounces between two points

  int exp_x[$];
  int exp_y[$];
  int exp_err;

  circle_tracer #(.W(W), .STEP_LAT(STEP_LAT), .MAX_STEPS(MAX_STEPS)) dut (
    .mclock  (mclock),
    .reset   (reset),
    .start   (start),
    .radius  (radius),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .st_x    (st_x),
    .st_y    (st_y),
    .st_r2   (st_r2),
    .st_ox   (st_ox),
    .st_oy   (st_oy),
    .pt_x    (pt_x),
    .pt_y    (pt_y),
    .pt_valid(pt_valid),
    .pt_ready(pt_ready),
    .pt_count(pt_count)
  );

  initial mclock = 1'b0;
  always #5 mclock = ~mclock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Clockwise walk: best of three neighbour candidates for the quadrant the point is in
  function automatic void step_fn(input int x, input int y, input int r2, input int m,
                                  output int nx, output int ny);
    int cx[3];
    int cy[3];
    int best;
    int e;
    if (m == 1) begin
      nx = x; ny = y;
      return;
    end
    if (m == 2) begin
      if (x == 1 && y == 1) begin nx = 2; ny = 2; end
      else begin nx = 1; ny = 1; end
      return;
    end
    if (x >= 0 && y > 0) begin
      cx = '{x + 1, x, x + 1}; cy = '{y, y - 1, y - 1};
    end else if (x > 0 && y <= 0) begin
      cx = '{x, x - 1, x - 1}; cy = '{y - 1, y, y - 1};
    end else if (x <= 0 && y < 0) begin
      cx = '{x - 1, x, x - 1}; cy = '{y, y + 1, y + 1};
    end else begin
      cx = '{x, x + 1, x + 1}; cy = '{y + 1, y, y + 1};
    end
    nx = cx[0]; ny = cy[0];
    best = iabs(cx[0] * cx[0] + cy[0] * cy[0] - r2);
    for (int i = 1; i < 3; i++) begin
      e = iabs(cx[i] * cx[i] + cy[i] * cy[i] - r2);
      if (e < best) begin
        best = e; nx = cx[i]; ny = cy[i];
      end
    end
  endfunction

  always @(posedge mclock) begin : stepper
    int sx;
    int sy;
    step_fn(int'($signed(st_x)), int'($signed(st_y)), int'(st_r2), mode, sx, sy);
    st_ox <= W'(sx);
    st_oy <= W'(sy);
  end

  // Expected emitted points and final error code for one circle
  task automatic build_ref(input int r, input int m);
    int cx, cy, nx, ny;
    exp_x.delete();
    exp_y.delete();
    exp_err = 0;
    if (r * r >= 32768) begin
      exp_err = 1;
      return;
    end
    cx = 0; cy = r;
    while (exp_x.size() <= MAX_STEPS) begin
      exp_x.push_back(cx);
      exp_y.push_back(cy);
      if (r == 0) break;
      if (exp_x.size() == MAX_STEPS) begin exp_err = 3; break; end
      step_fn(cx, cy, r * r, m, nx, ny);
      if (nx == cx && ny == cy) begin exp_err = 2; break; end
      if (nx == 0 && ny == r) break;
      cx = nx; cy = ny;
    end
  endtask

  // rdy_mode: 0 always ready, 1 ready one cycle in three, 2 random; poke>=0 pulses start mid-run
  task automatic run_circle(input string tag, input int r, input int m, input int rdy_mode, input int poke);
    int got_x[$];
    int got_y[$];
    int dones = 0, unstable = 0, stray = 0, cyc = 0, done_cyc = -1, t0 = -1, t1 = -1, n;
    logic held;
    logic [W-1:0] px, py;
    mode = m;
    build_ref(r, m);
    @(negedge mclock);
    start = 1'b1; radius = W'(r); pt_ready = 1'b0;
    @(negedge mclock);
    start = 1'b0;
    held = 1'b0; px = '0; py = '0;
    while (cyc < 20000) begin
      if (held && (pt_valid !== 1'b1 || pt_x !== px || pt_y !== py)) unstable++;
      if (pt_valid && !busy) stray++;
      if (done) begin dones++; done_cyc = cyc; break; end
      case (rdy_mode)
        0:       pt_ready = 1'b1;
        1:       pt_ready = (cyc % 3 == 0);
        default: pt_ready = 1'($urandom_range(0, 1));
      endcase
      start = (cyc == poke);
      if (cyc == poke) radius = W'(1);
      if (pt_valid && pt_ready) begin
        got_x.push_back(int'($signed(pt_x)));
        got_y.push_back(int'($signed(pt_y)));
        if (t0 < 0) t0 = cyc;
        else if (t1 < 0) t1 = cyc;
      end
      held = pt_valid && !pt_ready;
      px = pt_x; py = pt_y;
      @(negedge mclock);
      cyc++;
    end
    start = 1'b0;
    pt_ready = 1'b0;
    check({tag, ".done_seen"}, 64'(dones), 64'd1);
    check({tag, ".npts"}, 64'(got_x.size()), 64'(exp_x.size()));
    n = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.pt%0d", tag, i), {32'(got_x[i]), 32'(got_y[i])}, {32'(exp_x[i]), 32'(exp_y[i])});
    check({tag, ".err"}, 64'(err), 64'(exp_err));
    check({tag, ".pt_count"}, 64'(pt_count), 64'(exp_x.size()));
    check({tag, ".stable"}, 64'(unstable), 64'd0);
    check({tag, ".valid_in_busy"}, 64'(stray), 64'd0);
    if (exp_err == 1) check({tag, ".done_lat"}, 64'(done_cyc), 64'd0);
    if (rdy_mode == 0 && t1 >= 0) check({tag, ".tput"}, 64'(t1 - t0), 64'(STEP_LAT + 3));
    @(negedge mclock);
    check({tag, ".done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, ".idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".ctl"}, {59'd0, busy, done, err, pt_valid}, 64'd0);
    check({tag, ".pt"}, {16'd0, pt_x, pt_y, pt_count}, 64'd0);
    check({tag, ".st"}, {16'd0, st_x, st_y, st_r2}, 64'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; radius = '0; pt_ready = 1'b0;
    #1 reset = 1'b1;
    #1 check_zero("por");
    repeat (2) @(negedge mclock);
    reset = 1'b0;

    run_circle("r0", 0, 0, 0, -1);
    run_circle("r1", 1, 0, 0, -1);
    run_circle("r5", 5, 0, 0, -1);
    run_circle("r5_third", 5, 0, 1, -1);
    run_circle("r5_rand", 5, 0, 2, -1);
    run_circle("r5_busy_start", 5, 0, 2, 6);
    run_circle("r200", 200, 0, 0, -1);
    run_circle("r182", 182, 0, 0, -1);
    run_circle("r181", 181, 0, 0, -1);
    for (int k = 0; k < 3; k++)
      run_circle($sformatf("rnd%0d", k), int'($urandom_range(2, 40)), 0, 2, -1);
    run_circle("stall", 3, 1, 0, -1);
    run_circle("wdog", 3, 2, 0, -1);

    // Async reset while a point is waiting in EMIT
    mode = 0;
    @(negedge mclock);
    start = 1'b1; radius = W'(10); pt_ready = 1'b0;
    @(negedge mclock);
    start = 1'b0;
    repeat (3) @(negedge mclock);
    check("rst.pre_valid", {63'd0, pt_valid}, 64'd1);
    #2 reset = 1'b1;
    #1 check_zero("rst.async");
    repeat (2) begin
      @(negedge mclock);
      check("rst.no_done", {63'd0, done}, 64'd0);
    end
    reset = 1'b0;
    run_circle("r1_after_rst", 1, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
